// File: rtl/sort_pkg.sv
// Shared types and constants for the 4-element, 8-bit sorting pipeline.
package sort_pkg;

    localparam int ELEM_W   = 8;
    localparam int N_ELEM   = 4;
    localparam int SORT_LAT = 4;
    localparam int JOB_W    = ELEM_W * N_ELEM;

    typedef logic [ELEM_W-1:0] elem_t;
    typedef logic [N_ELEM-1:0][ELEM_W-1:0] job_t;

    typedef struct packed {
        elem_t hi;
        elem_t lo;
    } pair_t;

    // Compare-exchange: the basic cell of the sorting network.
    function automatic pair_t order2(input elem_t a, input elem_t b);
        pair_t p;
        if (a <= b) begin
            p.lo = a;
            p.hi = b;
        end else begin
            p.lo = b;
            p.hi = a;
        end
        return p;
    endfunction

endpackage

// File: rtl/sort4_core.sv
// Four-stage, free-running ascending sort of four 8-bit elements.
// out_data[7:0] is the minimum and out_data[31:24] the maximum.
module sort4_core
    import sort_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  job_t in_data,
    output job_t out_data
);

    job_t  s0;
    pair_t s1_a, s1_b;
    elem_t s2_min, s2_mid_a, s2_mid_b, s2_max;

    pair_t c01, c23, c_lo, c_hi, c_mid;

    assign c01   = order2(s0[0], s0[1]);
    assign c23   = order2(s0[2], s0[3]);
    assign c_lo  = order2(s1_a.lo, s1_b.lo);
    assign c_hi  = order2(s1_a.hi, s1_b.hi);
    assign c_mid = order2(s2_mid_a, s2_mid_b);

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: data stages are reset as well, so res_data is never X after reset.
        if (!rst) begin
            s0       <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_min   <= '0;
            s2_mid_a <= '0;
            s2_mid_b <= '0;
            s2_max   <= '0;
            out_data <= '0;
        end else begin
            // NOTE: non-blocking, so each stage captures the previous stage's old value.
            s0       <= in_data;
            s1_a     <= c01;
            s1_b     <= c23;
            s2_min   <= c_lo.lo;
            s2_mid_a <= c_lo.hi;
            s2_mid_b <= c_hi.lo;
            s2_max   <= c_hi.hi;
            out_data <= {s2_max, c_mid.hi, c_mid.lo, s2_min};
        end
    end

endmodule

// File: rtl/sort4_sched.sv
// Round-robin scheduler sharing one sort4_core among NREQ requesters.
// Optional per-requester grant counters: define SORT_SCHED_STATS_EN.
module sort4_sched
    import sort_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TAGW = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*JOB_W-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    output logic [TAGW-1:0]       res_tag,
`ifdef SORT_SCHED_STATS_EN
    output logic [NREQ*16-1:0]    grant_cnt,
`endif
    output logic [JOB_W-1:0]      res_data
);

    localparam int LAT = SORT_LAT;

    logic [TAGW-1:0]          rr_ptr;
    logic [TAGW-1:0]          gnt_idx;
    logic                     fire;
    logic                     acc_valid;
    logic [TAGW-1:0]          acc_tag;
    job_t                     acc_job;
    logic [LAT-1:0]           vld_sr;
    logic [LAT-1:0][TAGW-1:0] tag_sr;
    job_t                     core_out;

    function automatic logic [TAGW-1:0] wrap_idx(input int v);
        return TAGW'(v % NREQ);
    endfunction

    // First valid requester at or after rr_ptr, wrapping; nothing while disabled or flushing.
    always_comb begin
        // NOTE: defaults first, so no path leaves an output unassigned (no latch).
        req_ready = '0;
        gnt_idx   = '0;
        fire      = 1'b0;
        if (en && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!fire && req_valid[wrap_idx(int'(rr_ptr) + k)]) begin
                    fire    = 1'b1;
                    gnt_idx = wrap_idx(int'(rr_ptr) + k);
                end
            end
            req_ready[gnt_idx] = fire;
        end
    end

    // Acceptance register, then a valid/tag shift aligned with the core stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= '0;
            acc_valid <= 1'b0;
            acc_tag   <= '0;
            acc_job   <= '0;
            vld_sr    <= '0;
            tag_sr    <= '0;
        end else begin
            acc_valid <= fire;
            vld_sr    <= flush ? '0 : {vld_sr[LAT-2:0], acc_valid};
            tag_sr    <= {tag_sr[LAT-2:0], acc_tag};
            if (fire) begin
                rr_ptr  <= (gnt_idx == TAGW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                acc_tag <= gnt_idx;
                acc_job <= req_data[int'(gnt_idx)*JOB_W +: JOB_W];
            end
        end
    end

    sort4_core u_core (
        .clk      (clk),
        .rst      (rst),
        .in_data  (acc_job),
        .out_data (core_out)
    );

    assign res_valid = vld_sr[LAT-1];
    assign res_tag   = tag_sr[LAT-1];
    assign res_data  = core_out;

`ifdef SORT_SCHED_STATS_EN
    logic [NREQ-1:0][15:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (fire && cnt[gnt_idx] != 16'hFFFF) begin
            cnt[gnt_idx] <= cnt[gnt_idx] + 16'd1;
        end
    end

    assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_sort4_sched.sv
// Scoreboard bench for sort4_sched: stimulus queues expected grants and results,
// a negedge monitor matches grants, result order, tags, data and latency.
module tb_sort4_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 flush;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*32-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 res_valid;
    logic [1:0]           res_tag;
    logic [31:0]          res_data;
`ifdef SORT_SCHED_STATS_EN
    logic [NREQ*16-1:0]   grant_cnt;
`endif

    sort4_sched dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_tag   (res_tag),
`ifdef SORT_SCHED_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .res_data  (res_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  tag;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          grant_q[$];
    logic [31:0] exp_sorted[NREQ];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          res_pulses = 0;
    int          pulses0;

    // Hand-sorted vectors: {e3,e2,e1,e0} in, ascending with minimum in [7:0] out.
    localparam logic [31:0] V0 = 32'h07010903, S0 = 32'h09070301;
    localparam logic [31:0] V1 = 32'h10203040, S1 = 32'h40302010;
    localparam logic [31:0] V2 = 32'hFF00FF00, S2 = 32'hFFFF0000;
    localparam logic [31:0] V3 = 32'h55555555, S3 = 32'h55555555;
    localparam logic [31:0] V4 = 32'h01020304, S4 = 32'h04030201;
    localparam logic [31:0] V5 = 32'h807F00FE, S5 = 32'hFE807F00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got 0x%0h, want nothing (cycle %0d)", name, act, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    exp_t       e_mon;
    int         g_mon;
    logic [3:0] fire_mon;

    always @(negedge clk) begin
        if (rst) begin
            if (res_valid) begin
                res_pulses++;
                if (exp_q.size() == 0) begin
                    fail("res_unexpected", {30'd0, res_tag, res_data});
                end else begin
                    e_mon = exp_q.pop_front();
                    check("res_tag", res_tag, e_mon.tag);
                    check("res_data", res_data, e_mon.data);
                    check("res_cycle", cyc, e_mon.cyc);
                end
            end
            fire_mon = req_ready & req_valid;
            if (req_ready != '0) check("ready_onehot", $onehot(req_ready), 1);
            if (fire_mon != '0) begin
                if (grant_q.size() == 0) begin
                    fail("grant_unexpected", fire_mon);
                end else begin
                    g_mon = grant_q.pop_front();
                    check("grant", fire_mon, 4'b0001 << g_mon);
                    e_mon.tag  = 2'(g_mon);
                    e_mon.data = exp_sorted[g_mon];
                    e_mon.cyc  = cyc + 1 + LAT;
                    exp_q.push_back(e_mon);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [31:0] v, input logic [31:0] s);
        req_data[i*32 +: 32] = v;
        exp_sorted[i]        = s;
    endtask

    task automatic drain(input string name);
        check({name, "_res_pending"}, exp_q.size(), 0);
        check({name, "_grant_pending"}, grant_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_q.delete();
        grant_q.delete();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        en        = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tick();
        tick();
        check("reset_res_valid", res_valid, 0);
        check("reset_res_tag", res_tag, 0);
        check("reset_res_data", res_data, 0);
        check("reset_req_ready", req_ready, 0);
        rst = 1'b1;

        // Single job from requester 0.
        en = 1'b1;
        load(0, V0, S0);
        grant_q.push_back(0);
        req_valid = 4'b0001;
        #1 check("single_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        repeat (6) tick();
        drain("single");

        // Grant enable low blocks acceptance.
        en = 1'b0;
        load(0, V4, S4);
        grant_q.push_back(0);
        req_valid = 4'b0001;
        repeat (3) begin
            tick();
            check("en_low_ready", req_ready, 4'b0000);
        end
        en = 1'b1;
        #1 check("en_high_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        repeat (6) tick();
        drain("enable");

        // Fairness: all requesters valid for 8 cycles from rr_ptr = 0.
        do_reset();
        load(0, V0, S0);
        load(1, V1, S1);
        load(2, V2, S2);
        load(3, V3, S3);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) grant_q.push_back(i);
        end
        req_valid = 4'b1111;
        repeat (8) tick();
        req_valid = '0;
        repeat (6) tick();
        drain("fair");

        // Skip and wrap: move rr_ptr to 3, then requesters 0 and 2 compete.
        load(2, V5, S5);
        grant_q.push_back(2);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        load(0, V4, S4);
        grant_q.push_back(0);
        grant_q.push_back(2);
        req_valid = 4'b0101;
        #1 check("wrap_ready_first", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0100;
        #1 check("wrap_ready_second", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        repeat (6) tick();
        drain("wrap");

        // Flush kills two in-flight jobs; a job waiting through the flush goes next.
        load(0, V0, S0);
        load(1, V1, S1);
        grant_q.push_back(0);
        grant_q.push_back(1);
        grant_q.push_back(0);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        flush     = 1'b1;
        req_valid = 4'b0001;
        pulses0   = res_pulses;
        exp_q.delete();
        #1 check("flush_ready", req_ready, 4'b0000);
        tick();
        flush = 1'b0;
        tick();
        req_valid = '0;
        repeat (8) tick();
        check("flush_pulses", res_pulses - pulses0, 1);
        drain("flush");

        // Asynchronous reset with jobs in flight.
        load(1, V2, S2);
        load(2, V3, S3);
        grant_q.push_back(1);
        grant_q.push_back(2);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        #2 rst = 1'b0;
        #1;
        check("midrst_res_valid", res_valid, 0);
        check("midrst_res_tag", res_tag, 0);
        check("midrst_res_data", res_data, 0);
        check("midrst_req_ready", req_ready, 0);
        exp_q.delete();
        pulses0 = res_pulses;
        tick();
        rst = 1'b1;
        repeat (8) tick();
        check("midrst_pulses", res_pulses - pulses0, 0);
        drain("midrst");

        // rr_ptr returned to 0: requester 0 wins over 3, then 3.
        load(0, V4, S4);
        load(3, V5, S5);
        grant_q.push_back(0);
        grant_q.push_back(3);
        req_valid = 4'b1001;
        tick();
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        repeat (6) tick();
        drain("post_rst");

`ifdef SORT_SCHED_STATS_EN
        do_reset();
        load(1, V1, S1);
        repeat (5) grant_q.push_back(1);
        req_valid = 4'b0010;
        repeat (5) tick();
        req_valid = '0;
        repeat (6) tick();
        drain("stats");
        check("stats_cnt0", grant_cnt[15:0], 0);
        check("stats_cnt1", grant_cnt[31:16], 5);
        check("stats_cnt2", grant_cnt[47:32], 0);
        check("stats_cnt3", grant_cnt[63:48], 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sort4_sched.md
# sort4_sched

Round-robin scheduler that shares one 4-element, 8-bit sorting pipeline among NREQ requesters. It sits in front of the sorting datapath and accepts at most one 4-value job per cycle through a valid/ready handshake. It tags each job with its requester index and returns the ascending result with the tag after a fixed latency. The pipeline never stalls, so one job per cycle is sustained when requests are continuous.

## Interface
- NREQ, 4: number of requesters, legal 2..4.
- TAGW, 2: tag width. It must satisfy 2^TAGW >= NREQ.
- LAT, 4: pipeline latency in cycles, from acceptance to result. It is fixed by the core.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-low.
- en  in  1  grant enable. While low, no new jobs are accepted and in-flight jobs drain normally.
- flush  in  1  synchronous kill of all in-flight jobs.
- req_valid  in  NREQ  per-requester job request.
- req_data  in  NREQ*32  per-requester job. Requester i occupies bits [32i+31:32i], and element j of that job occupies bits [32i+8j+7:32i+8j].
- req_ready  out  NREQ  one-hot grant (or all zero).
- res_valid  out  1  result valid, a one-cycle pulse per job.
- res_tag  out  TAGW  index of the requester that owns the result.
- res_data  out  32  sorted result. Bits [7:0] hold the minimum and bits [31:24] hold the maximum.
- grant_cnt  out  NREQ*16  per-requester accepted-job counters. This port exists only with SORT_SCHED_STATS_EN.

## Operation
- **Arbitration:**
  - A round-robin pointer `rr_ptr` (0..NREQ-1) marks the highest-priority requester.
  - req_ready[i] = en & ~flush & req_valid[i], for the first i that has valid set, searching from rr_ptr upward with wrap.
  - req_ready is combinational from req_valid, en, flush and rr_ptr, and is at most one-hot.
- **Acceptance:** a job is accepted when req_valid[i] & req_ready[i] are both high at a rising edge. On acceptance, rr_ptr <= (i+1) mod NREQ. With no acceptance, rr_ptr holds.
- **Requester rule:** once req_valid is raised, the requester keeps req_valid and req_data stable until accepted. Dropping valid before acceptance is illegal; the bench flags it.
- **Job tracking:** each accepted job enters the core together with a valid bit and its tag. The valid/tag pair travels in a LAT-deep shift register aligned with the data stages.
- **Sort core:**
  - Stage 0 registers the inputs.
  - Stage 1 sorts the pairs (e0,e1) and (e2,e3).
  - Stage 2 compares the two minima and the two maxima.
  - Stage 3 is the output register.
  - Equal values may appear in either order. Only the multiset and the ordering are checked.
- **Flush:** all valid bits in the tracking register clear at the next edge. No grant is issued in a flush cycle. Data registers are don't-care, and res_valid stays 0 until new jobs emerge.
- **Reset:** rst low clears everything asynchronously:
  - rr_ptr = 0;
  - all valid bits and tags = 0;
  - all data stages = 0;
  - res_valid = 0, res_tag = 0, res_data = 0;
  - grant_cnt = 0.
- **Reset mid-operation:** in-flight jobs are lost and no result is produced for them.

## Timing
- A job accepted at edge k has res_valid high during cycle k+4, from edge k+4 to edge k+5.
- Back-to-back acceptances give back-to-back result pulses in the same order.
- When res_valid = 0, res_data and res_tag are don't-care for checking but must not be X after reset.
- en falling stops grants in the same cycle. Jobs already accepted still complete.
- flush and acceptance cannot coincide, because ready is forced low during flush.
- A flush at edge f kills every job accepted at or before edge f-1.
- There is no output backpressure: the consumer must take each pulse.

## Configuration
- SORT_SCHED_STATS_EN:
  - When defined, the block contains one 16-bit counter per requester. Each counter increments on acceptance, saturates at 16'hFFFF and clears only on reset. The counters are exposed on grant_cnt.
  - When undefined, neither the counters nor the grant_cnt port exist.

## Structure
- **Shared package `sort_pkg`:**
  - element width constant ELEM_W = 8;
  - element count N_ELEM = 4;
  - latency constant SORT_LAT = 4;
  - job type (4 x 8-bit).
- **Sub-module `sort4_core`:** the LAT-stage data pipeline, with clk, rst, in_data and out_data. The scheduler adds arbitration and the valid/tag pipeline around it.

## Test plan
- **Single job:** after reset, req_valid = 4'b0001, req_data for requester 0 = {8'h07, 8'h01, 8'h09, 8'h03} (e3..e0 = 07,01,09,03), accepted at edge 1. Required: res_valid in cycle 5 only, res_tag = 0, res_data = {8'h09, 8'h07, 8'h03, 8'h01}.
- **Fairness:** all four requesters valid continuously for 8 cycles. Required: grants 0,1,2,3,0,1,2,3 and result tags in the same order, each 4 cycles later.
- **Skip and wrap:** rr_ptr = 3, req_valid = 4'b0101. Required: grant to 0, then rr_ptr = 1, then grant to 2.
- **Flush:** accept jobs at edges 1 and 2, assert flush during cycle 3. Required: no res_valid ever appears for those jobs, and req_ready = 0 during cycle 3.
- **Reset mid-flight:** pull rst low asynchronously between edges 2 and 3 with jobs in flight. Required: all outputs read 0 immediately, and no result pulse after release.
- **Stats build:** with SORT_SCHED_STATS_EN defined, accept 5 jobs from requester 1. Required: grant_cnt[31:16] = 5 and all other counters = 0.
